ov7670_cfg_sequencer: RTL and testbench
=======================================

// Module: ov7670_cfg_sequencer
// PURPOSE
// - Walks the OV7670 register-config LUT from LUT_START to LUT_END after reset or on cfg_start.
// - Drives each 16-bit entry {reg_addr[15:8], reg_data[7:0]} as one SCCB write to the SCCB/I2C master.
// - Sits between the config LUT (combinational, index -> data) and the SCCB master; gates camera capture via cfg_done.
// PARAMETERS
// - LUT_START     2          first LUT index issued
// - LUT_END       166        last LUT index issued (inclusive)
// - PWRUP_CYCLES  1_000_000  wait after reset/start before first write (20 ms @ 50 MHz)
// - GAP_CYCLES    5_000      idle cycles between consecutive writes
// - RST_GAP       500_000    gap after a write to reg 0x12 with data[7]=1 (soft reset)
// - MAX_RETRY     3          NACK retries per entry (CFG_RETRY_EN only)
// PORTS
// - clk        in   1   system clock
// - rst        in   1   asynchronous reset, active high
// - cfg_start  in   1   1-cycle pulse: restart full sequence (ignored while busy)
// - lut_index  out  8   index to config LUT
// - lut_data   in   16  LUT entry for lut_index (valid one cycle after lut_index changes)
// - sccb_req   out  1   write request, held until sccb_ack
// - sccb_addr  out  8   register address, stable while sccb_req or awaiting done
// - sccb_data  out  8   register data, stable likewise
// - sccb_ack   in   1   1-cycle pulse: master accepted request
// - sccb_done  in   1   1-cycle pulse: transfer finished
// - sccb_nack  in   1   sampled with sccb_done: 1 = slave NACK
// - cfg_busy   out  1   sequence in progress
// - cfg_done   out  1   all entries written OK (sticky until next start)
// - cfg_err    out  1   aborted on NACK (sticky until next start)
// BEHAVIOUR
// - Reset values: lut_index=LUT_START, sccb_req=0, sccb_addr=0, sccb_data=0, cfg_busy=0, cfg_done=0, cfg_err=0; state=PWR_WAIT, counter=0.
// - Sequence auto-starts on reset release; cfg_busy=1 from first clk edge after rst deassert.
// - States: IDLE, PWR_WAIT, FETCH, ISSUE, WAIT_DONE, GAP, DONE, ERROR.
// - PWR_WAIT: count PWRUP_CYCLES, then FETCH. FETCH (1 cycle): latch lut_data into sccb_addr/sccb_data -> ISSUE.
// - ISSUE: sccb_req=1; on sccb_ack drop sccb_req same edge -> WAIT_DONE. No timeout.
// - WAIT_DONE on sccb_done: nack=0 -> GAP; nack=1 -> ERROR (or retry, see CONFIGURATION).
// - GAP: count GAP_CYCLES (RST_GAP if sccb_addr==8'h12 && sccb_data[7]); then if lut_index==LUT_END -> DONE, else lut_index+1 -> FETCH.
// - lut_index never exceeds LUT_END; no wrap. LUT_START>LUT_END is illegal (not checked).
// - DONE: cfg_done=1, cfg_busy=0. ERROR: cfg_err=1, cfg_busy=0, lut_index holds failing entry.
// - IDLE/DONE/ERROR + cfg_start: clear cfg_done/cfg_err, lut_index=LUT_START, cfg_busy=1 -> PWR_WAIT.
// - cfg_start while busy: ignored. sccb_ack and sccb_done same cycle in ISSUE: treated as ack then done next state; master must not do this (assert in sim).
// - Counters sized clog2(max(PWRUP_CYCLES,RST_GAP))+1; counter reset to 0 on every state entry.
// - rst mid-transfer: immediate return to reset values; SCCB master is reset by same rst.
// CONFIGURATION
// - OV_CFG_RETRY_EN defined: NACK with retry_cnt<MAX_RETRY -> GAP (normal gap) then re-FETCH same index, retry_cnt+1;
//   retry_cnt cleared on each successful write; NACK with retry_cnt==MAX_RETRY -> ERROR.
// - OV_CFG_RETRY_EN undefined: first NACK -> ERROR; no retry counter logic.
// TESTING (bench params: PWRUP_CYCLES=10, GAP_CYCLES=4, RST_GAP=20, LUT 2..166, SCCB model acks 2 cycles after req, done 10 later)
// - Reset release, all ACK -> 165 writes, first {0x12,0x14}, last {0x3b,0x42}; cfg_done=1, cfg_busy=0 after last gap.
// - Check first sccb_req rises exactly PWRUP_CYCLES+2 cycles after rst release; inter-write gap >= 4 idle cycles.
// - LUT entry 0x1280 injected at index 5 -> gap after that write is 20 cycles, others 4.
// - NACK on index 40, macro off -> cfg_err=1, cfg_done=0, lut_index=40, no further sccb_req.
// - NACK twice on index 40, OV_CFG_RETRY_EN on, MAX_RETRY=3 -> index 40 issued 3 times, sequence completes, cfg_done=1.
// - rst pulsed while in WAIT_DONE at index 80 -> outputs at reset values; sequence restarts from index 2; cfg_start while busy ignored.

Source files
------------

// File: rtl/ov7670_cfg_sequencer_if.sv
// SCCB write-request channel between the OV7670 config sequencer (master) and the SCCB/I2C engine (slave).
interface ov7670_cfg_sequencer_if;
    logic       sccb_req;
    logic [7:0] sccb_addr;
    logic [7:0] sccb_data;
    logic       sccb_ack;
    logic       sccb_done;
    logic       sccb_nack;

    modport master (
        output sccb_req,
        output sccb_addr,
        output sccb_data,
        input  sccb_ack,
        input  sccb_done,
        input  sccb_nack
    );

    modport slave (
        input  sccb_req,
        input  sccb_addr,
        input  sccb_data,
        output sccb_ack,
        output sccb_done,
        output sccb_nack
    );
endinterface

// File: rtl/ov7670_cfg_sequencer.sv
// OV7670 register-config sequencer: walks the config LUT and issues one SCCB write per entry.
// Define OV_CFG_RETRY_EN to retry NACKed writes up to MAX_RETRY times before aborting.
module ov7670_cfg_sequencer #(
`ifdef OV_CFG_RETRY_EN
    parameter int unsigned MAX_RETRY    = 3,
`endif
    parameter int unsigned LUT_START    = 2,
    parameter int unsigned LUT_END      = 166,
    parameter int unsigned PWRUP_CYCLES = 1_000_000,
    parameter int unsigned GAP_CYCLES   = 5_000,
    parameter int unsigned RST_GAP      = 500_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    output logic [7:0]             lut_index,
    input  logic [15:0]            lut_data,
    ov7670_cfg_sequencer_if.master sccb,
    output logic                   cfg_busy,
    output logic                   cfg_done,
    output logic                   cfg_err
);

    localparam int unsigned WAIT_MAX = (PWRUP_CYCLES > RST_GAP) ? PWRUP_CYCLES : RST_GAP;
    localparam int unsigned CNT_W    = $clog2(WAIT_MAX) + 1;

    localparam logic [CNT_W-1:0] PWR_LAST     = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_GAP_LAST = CNT_W'(RST_GAP - 1);
    localparam logic [7:0]       IDX_FIRST    = 8'(LUT_START);
    localparam logic [7:0]       IDX_LAST     = 8'(LUT_END);

    typedef enum logic [2:0] {
        IDLE,
        PWR_WAIT,
        FETCH,
        ISSUE,
        WAIT_DONE,
        GAP,
        DONE,
        ERROR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             done_pend;
    logic             nack_pend;
    logic             done_now;
    logic             nack_now;
    logic             soft_rst_gap;
    logic [CNT_W-1:0] gap_last;

`ifdef OV_CFG_RETRY_EN
    localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

    logic [RETRY_W-1:0] retry_cnt;
    logic               redo;
`endif

    // A done that arrived together with ack is held so WAIT_DONE still sees it.
    always_comb begin
        done_now = sccb.sccb_done | done_pend;
        nack_now = done_pend ? nack_pend : sccb.sccb_nack;
    end

    // Writing COM7 with bit 7 set soft-resets the sensor, which needs a much longer settle.
    always_comb begin
        soft_rst_gap = (sccb.sccb_addr == 8'h12) && sccb.sccb_data[7];
`ifdef OV_CFG_RETRY_EN
        if (redo) begin
            soft_rst_gap = 1'b0;
        end
`endif
        gap_last = soft_rst_gap ? RST_GAP_LAST : GAP_LAST;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= PWR_WAIT;
            cnt            <= '0;
            lut_index      <= IDX_FIRST;
            sccb.sccb_req  <= 1'b0;
            sccb.sccb_addr <= 8'h00;
            sccb.sccb_data <= 8'h00;
            cfg_busy       <= 1'b0;
            cfg_done       <= 1'b0;
            cfg_err        <= 1'b0;
            done_pend      <= 1'b0;
            nack_pend      <= 1'b0;
`ifdef OV_CFG_RETRY_EN
            retry_cnt      <= '0;
            redo           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (cfg_start) begin
                        cfg_done  <= 1'b0;
                        cfg_err   <= 1'b0;
                        cfg_busy  <= 1'b1;
                        lut_index <= IDX_FIRST;
                        cnt       <= '0;
`ifdef OV_CFG_RETRY_EN
                        retry_cnt <= '0;
                        redo      <= 1'b0;
`endif
                        state     <= PWR_WAIT;
                    end
                end

                PWR_WAIT: begin
                    cfg_busy <= 1'b1;
                    if (cnt == PWR_LAST) begin
                        cnt   <= '0;
                        state <= FETCH;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                FETCH: begin
                    sccb.sccb_addr <= lut_data[15:8];
                    sccb.sccb_data <= lut_data[7:0];
                    cnt            <= '0;
                    state          <= ISSUE;
                end

                ISSUE: begin
                    if (sccb.sccb_ack) begin
                        sccb.sccb_req <= 1'b0;
                        done_pend     <= sccb.sccb_done;
                        nack_pend     <= sccb.sccb_nack;
                        cnt           <= '0;
                        state         <= WAIT_DONE;
                    end else begin
                        sccb.sccb_req <= 1'b1;
                    end
                end

                WAIT_DONE: begin
                    if (done_now) begin
                        done_pend <= 1'b0;
                        nack_pend <= 1'b0;
                        cnt       <= '0;
                        if (nack_now) begin
`ifdef OV_CFG_RETRY_EN
                            if (retry_cnt < RETRY_LIMIT) begin
                                retry_cnt <= retry_cnt + RETRY_W'(1);
                                redo      <= 1'b1;
                                state     <= GAP;
                            end else begin
                                cfg_err  <= 1'b1;
                                cfg_busy <= 1'b0;
                                state    <= ERROR;
                            end
`else
                            cfg_err  <= 1'b1;
                            cfg_busy <= 1'b0;
                            state    <= ERROR;
`endif
                        end else begin
`ifdef OV_CFG_RETRY_EN
                            retry_cnt <= '0;
`endif
                            state <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (cnt == gap_last) begin
                        cnt <= '0;
`ifdef OV_CFG_RETRY_EN
                        if (redo) begin
                            redo  <= 1'b0;
                            state <= FETCH;
                        end else
`endif
                        if (lut_index == IDX_LAST) begin
                            cfg_done <= 1'b1;
                            cfg_busy <= 1'b0;
                            state    <= DONE;
                        end else begin
                            lut_index <= lut_index + 8'd1;
                            state     <= FETCH;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // The SCCB master must not accept and complete a request in the same cycle.
    ack_done_overlap: assert property (@(posedge clk) disable iff (rst)
        !(state == ISSUE && sccb.sccb_ack && sccb.sccb_done));
`endif

endmodule

// File: tb/tb_ov7670_cfg_sequencer.sv
// Scoreboard bench for ov7670_cfg_sequencer with a behavioural LUT and SCCB master model.
module tb_ov7670_cfg_sequencer;

    typedef struct {
        logic [7:0]  idx;
        logic [15:0] entry;
        int          gap;
    } wr_t;

    logic        clk;
    logic        rst;
    logic        cfg_start;
    logic [7:0]  lut_index;
    logic [15:0] lut_data;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        inject;

    int checks;
    int failures;
    int cyc;
    int last_evt;
    logic start_mark;
    int nack_idx;
    int nack_left;
    wr_t exp_q[$];

    ov7670_cfg_sequencer_if sccb_if ();

    ov7670_cfg_sequencer #(
        .LUT_START   (2),
        .LUT_END     (166),
        .PWRUP_CYCLES(10),
        .GAP_CYCLES  (4),
        .RST_GAP     (20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_start(cfg_start),
        .lut_index(lut_index),
        .lut_data (lut_data),
        .sccb     (sccb_if),
        .cfg_busy (cfg_busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] lut_entry(input logic [7:0] idx, input logic inj);
        logic [7:0] d;
        if (idx == 8'd2) return 16'h1214;
        if (idx == 8'd166) return 16'h3b42;
        if (idx == 8'd5 && inj) return 16'h1280;
        d = idx ^ 8'h5a;
        return {idx, d};
    endfunction

    always_comb lut_data = lut_entry(lut_index, inject);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected writes: gap is edges from start/reset-release/previous done to req rise.
    task automatic push_seq(input logic inj, input int last_idx, input int rep_idx, input int rep_n);
        int g;
        for (int i = 2; i <= last_idx; i++) begin
            if (i == 2) g = 12;
            else if (inj && i == 6) g = 22;
            else g = 6;
            exp_q.push_back('{idx: 8'(i), entry: lut_entry(8'(i), inj), gap: g});
            if (i == rep_idx) begin
                for (int r = 0; r < rep_n; r++)
                    exp_q.push_back('{idx: 8'(i), entry: lut_entry(8'(i), inj), gap: 6});
            end
        end
    endtask

    task automatic pulse_start(input logic honoured);
        cfg_start = 1'b1;
        if (honoured) start_mark = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_flag(input string name, input logic want_err, input int budget);
        int n;
        n = 0;
        while (!(want_err ? cfg_err : cfg_done) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout waited=%0d cycles", name, n);
        end
    endtask

    // SCCB master model: ack 2 cycles after req, done 10 cycles after ack.
    int m_phase;
    int m_cnt;
    initial begin
        sccb_if.sccb_ack  = 1'b0;
        sccb_if.sccb_done = 1'b0;
        sccb_if.sccb_nack = 1'b0;
        m_phase = 0;
        m_cnt   = 0;
        forever begin
            @(negedge clk);
            sccb_if.sccb_ack  = 1'b0;
            sccb_if.sccb_done = 1'b0;
            sccb_if.sccb_nack = 1'b0;
            if (rst) begin
                m_phase = 0;
            end else begin
                case (m_phase)
                    0: if (sccb_if.sccb_req) m_phase = 1;
                    1: begin
                        sccb_if.sccb_ack = 1'b1;
                        m_cnt   = 0;
                        m_phase = 2;
                    end
                    default: begin
                        m_cnt++;
                        if (m_cnt == 10) begin
                            sccb_if.sccb_done = 1'b1;
                            if (int'(lut_index) == nack_idx && nack_left > 0) begin
                                sccb_if.sccb_nack = 1'b1;
                                nack_left--;
                            end
                            m_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard on every sccb_req rise.
    logic        prev_req;
    logic [15:0] held;
    wr_t         e;
    initial begin
        cyc      = 0;
        last_evt = 0;
        prev_req = 1'b0;
        held     = 16'h0;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst || sccb_if.sccb_done || start_mark) begin
                last_evt   = cyc;
                start_mark = 1'b0;
            end
            #1;
            if (!rst && sccb_if.sccb_req && !prev_req) begin
                held = {sccb_if.sccb_addr, sccb_if.sccb_data};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write idx=%0d entry=%h", lut_index, held);
                end else begin
                    e = exp_q.pop_front();
                    check("write_idx", 32'(lut_index), 32'(e.idx));
                    check("write_entry", 32'(held), 32'(e.entry));
                    check("write_gap", cyc - last_evt, e.gap);
                end
            end else if (!rst && sccb_if.sccb_req && prev_req) begin
                check("req_payload_stable", 32'({sccb_if.sccb_addr, sccb_if.sccb_data}), 32'(held));
            end
            prev_req = sccb_if.sccb_req;
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_lut_index"}, 32'(lut_index), 32'd2);
        check({tag, "_req"}, 32'(sccb_if.sccb_req), 32'd0);
        check({tag, "_addr"}, 32'(sccb_if.sccb_addr), 32'h00);
        check({tag, "_data"}, 32'(sccb_if.sccb_data), 32'h00);
        check({tag, "_busy"}, 32'(cfg_busy), 32'd0);
        check({tag, "_done"}, 32'(cfg_done), 32'd0);
        check({tag, "_err"}, 32'(cfg_err), 32'd0);
    endtask

    initial begin
        int n;
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        cfg_start  = 1'b0;
        inject     = 1'b0;
        start_mark = 1'b0;
        nack_idx   = 0;
        nack_left  = 0;

        // Reset values, then auto-start on release
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        push_seq(1'b0, 166, 0, 0);
        rst = 1'b0;
        #1;
        check("busy_before_first_edge", 32'(cfg_busy), 32'd0);
        @(negedge clk);
        check("busy_after_first_edge", 32'(cfg_busy), 32'd1);
        wait_flag("run_plain", 1'b0, 6000);
        check("run_plain_done", 32'(cfg_done), 32'd1);
        check("run_plain_busy", 32'(cfg_busy), 32'd0);
        check("run_plain_err", 32'(cfg_err), 32'd0);
        check("run_plain_last_idx", 32'(lut_index), 32'd166);
        check("run_plain_all_written", 32'(exp_q.size()), 32'd0);

        // Restart from DONE with a soft-reset entry injected at index 5
        inject = 1'b1;
        push_seq(1'b1, 166, 0, 0);
        pulse_start(1'b1);
        check("restart_done_cleared", 32'(cfg_done), 32'd0);
        check("restart_busy", 32'(cfg_busy), 32'd1);
        wait_flag("run_inject", 1'b0, 6000);
        check("run_inject_done", 32'(cfg_done), 32'd1);
        check("run_inject_all_written", 32'(exp_q.size()), 32'd0);
        inject = 1'b0;

        // NACK at index 40
        nack_idx = 40;
`ifdef OV_CFG_RETRY_EN
        nack_left = 2;
        push_seq(1'b0, 166, 40, 2);
        pulse_start(1'b1);
        wait_flag("run_retry", 1'b0, 6000);
        check("retry_done", 32'(cfg_done), 32'd1);
        check("retry_err", 32'(cfg_err), 32'd0);
        check("retry_nacks_used", 32'(nack_left), 32'd0);
        check("retry_all_written", 32'(exp_q.size()), 32'd0);
`else
        nack_left = 1;
        push_seq(1'b0, 40, 0, 0);
        pulse_start(1'b1);
        wait_flag("run_nack", 1'b1, 6000);
        check("nack_err", 32'(cfg_err), 32'd1);
        check("nack_done", 32'(cfg_done), 32'd0);
        check("nack_busy", 32'(cfg_busy), 32'd0);
        check("nack_idx", 32'(lut_index), 32'd40);
        repeat (100) @(negedge clk);
        check("nack_no_more_req", 32'(sccb_if.sccb_req), 32'd0);
        check("nack_idx_held", 32'(lut_index), 32'd40);
        check("nack_all_written", 32'(exp_q.size()), 32'd0);
`endif
        nack_idx  = 0;
        nack_left = 0;

        // Reset pulse while waiting for done at index 80
        push_seq(1'b0, 166, 0, 0);
        pulse_start(1'b1);
        check("restart_err_cleared", 32'(cfg_err), 32'd0);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(sccb_if.sccb_ack && lut_index == 8'd80) && n < 4000);
        checks++;
        if (n >= 4000) begin
            failures++;
            $display("FAIL idx80_ack_timeout waited=%0d cycles", n);
        end
        repeat (2) @(negedge clk);
        check("wait_done_req_low", 32'(sccb_if.sccb_req), 32'd0);
        check("wait_done_busy", 32'(cfg_busy), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        #1;
        check_reset_values("midrst");
        repeat (2) @(negedge clk);
        push_seq(1'b0, 166, 0, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        pulse_start(1'b0);
        n = 0;
        while (lut_index != 8'd100 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        pulse_start(1'b0);
        wait_flag("run_after_rst", 1'b0, 6000);
        check("after_rst_done", 32'(cfg_done), 32'd1);
        check("after_rst_busy", 32'(cfg_busy), 32'd0);
        check("after_rst_all_written", 32'(exp_q.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
